sample_window_ctrl: RTL and testbench

SAMPLE_WINDOW_CTRL -- requirements
Module: sample_window_ctrl

---
 rtl/sample_window_ctrl.sv | 138 +++++++++++++
 tb/tb_sample_window_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sample_window_ctrl.sv
// Sliding-window controller that feeds a downstream shift register and hands complete windows to the next layer.
// Optional frame-end handling via last_i is enabled by defining WINDOW_FRAME_LAST_EN.
module sample_window_ctrl #(
   parameter int WORD_SIZE     = 16,
   parameter int WINDOW_LENGTH = 10,
   parameter int STRIDE        = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [WORD_SIZE-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [WORD_SIZE-1:0] shift_data_o,
   output logic                 shift_en_o,
   output logic                 window_valid_o,
   input  logic                 window_ready_i,
`ifdef WINDOW_FRAME_LAST_EN
   input  logic                 last_i,
`endif
   output logic [15:0]          window_count_o
);

   localparam int CW = $clog2(WINDOW_LENGTH + 1);
   localparam logic [CW-1:0] C_WLEN   = CW'(WINDOW_LENGTH);
   localparam logic [CW-1:0] C_STRIDE = CW'(STRIDE);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_HOLD   = 2'd1,
      S_STRIDE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_stateNext;
   logic [CW-1:0] r_fillCount;
   logic [CW-1:0] w_fillNext;
   logic [CW-1:0] r_strideCount;
   logic [CW-1:0] w_strideNext;
   logic [15:0]   r_windowCount;
   logic [15:0]   w_windowCountNext;
   logic          r_restart;
   logic          w_restartNext;
   logic          w_accept;
   logic          w_last;
   logic [CW-1:0] w_fillInc;
   logic [CW-1:0] w_strideInc;

`ifdef WINDOW_FRAME_LAST_EN
   assign w_last = last_i;
`else
   assign w_last = 1'b0;
`endif

   // Samples pass straight through to the shift register; only the enable is gated.
   assign ready_o        = ~reset_i & (r_state != S_HOLD);
   assign w_accept       = valid_i & ready_o;
   assign shift_en_o     = w_accept;
   assign shift_data_o   = data_i;
   assign window_valid_o = (r_state == S_HOLD);
   assign window_count_o = r_windowCount;

   assign w_fillInc   = r_fillCount + CW'(1);
   assign w_strideInc = r_strideCount + CW'(1);

   always_comb begin
      w_stateNext       = r_state;
      w_fillNext        = r_fillCount;
      w_strideNext      = r_strideCount;
      w_windowCountNext = r_windowCount;
      w_restartNext     = r_restart;
      case (r_state)
         S_FILL: begin
            if (w_accept) begin
               if (w_fillInc == C_WLEN) begin
                  w_stateNext   = S_HOLD;
                  w_fillNext    = C_WLEN;
                  w_restartNext = w_last;
               end else if (w_last) begin
                  w_fillNext = '0;
               end else begin
                  w_fillNext = w_fillInc;
               end
            end
         end
         S_HOLD: begin
            // r_restart marks a window that closed a frame: refill instead of striding.
            if (window_ready_i) begin
               w_windowCountNext = r_windowCount + 16'd1;
               w_strideNext      = '0;
               if (r_restart) begin
                  w_stateNext   = S_FILL;
                  w_fillNext    = '0;
                  w_restartNext = 1'b0;
               end else begin
                  w_stateNext = S_STRIDE;
               end
            end
         end
         S_STRIDE: begin
            if (w_accept) begin
               if (w_strideInc == C_STRIDE) begin
                  w_stateNext   = S_HOLD;
                  w_strideNext  = C_STRIDE;
                  w_restartNext = w_last;
               end else if (w_last) begin
                  w_stateNext  = S_FILL;
                  w_fillNext   = '0;
                  w_strideNext = '0;
               end else begin
                  w_strideNext = w_strideInc;
               end
            end
         end
         default: begin
            w_stateNext  = S_FILL;
            w_fillNext   = '0;
            w_strideNext = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state       <= S_FILL;
         r_fillCount   <= '0;
         r_strideCount <= '0;
         r_windowCount <= '0;
         r_restart     <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_fillCount   <= w_fillNext;
         r_strideCount <= w_strideNext;
         r_windowCount <= w_windowCountNext;
         r_restart     <= w_restartNext;
      end
   end

endmodule

// File: tb/tb_sample_window_ctrl.sv
// Randomised scoreboard bench for sample_window_ctrl; windows are predicted from accept counts since the last restart.
module tb_sample_window_ctrl;

   localparam int W  = 16;
   localparam int WL = 10;
   localparam int S  = 3;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic [W-1:0]  data_i = '0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [W-1:0]  shift_data_o;
   logic          shift_en_o;
   logic          window_valid_o;
   logic          window_ready_i = 1'b0;
   logic          last_i = 1'b0;
   logic [15:0]   window_count_o;

   sample_window_ctrl #(.WORD_SIZE(W), .WINDOW_LENGTH(WL), .STRIDE(S)) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .data_i(data_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .shift_data_o(shift_data_o),
      .shift_en_o(shift_en_o),
      .window_valid_o(window_valid_o),
      .window_ready_i(window_ready_i),
`ifdef WINDOW_FRAME_LAST_EN
      .last_i(last_i),
`endif
      .window_count_o(window_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0]     cnt;
      logic [WL*W-1:0] win;
   } expWindow_t;

   expWindow_t    scoreQ[$];
   logic [W-1:0]  hist[$];
   int            nTests = 0;
   int            nFail = 0;
   int            mN = 0;
   bit            mHolding = 0;
   bit            mRestart = 0;
   logic [15:0]   mCount = '0;
   logic [WL*W-1:0] downstream = '0;

   // Downstream shift register, newest sample in the low word.
   always @(posedge clk_i) begin
      if (shift_en_o) downstream <= {downstream[(WL-1)*W-1:0], shift_data_o};
   end

   task automatic checkOutput(input string name, input logic [WL*W-1:0] act, input logic [WL*W-1:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit v, input bit wr, input bit rst, input bit lst);
      logic [W-1:0] d;
      bit expReady;
      bit complete;
      expWindow_t e;
      @(negedge clk_i);
      d = W'($urandom);
      valid_i = v;
      data_i = d;
      window_ready_i = wr;
      reset_i = rst;
      last_i = lst;
      #1;
      expReady = !rst && !mHolding;
      checkOutput("ready_o", ready_o, expReady);
      checkOutput("shift_en_o", shift_en_o, v && expReady);
      checkOutput("window_valid_o", window_valid_o, mHolding);
      checkOutput("window_count_o", window_count_o, mCount);
      @(posedge clk_i);
      if (rst) begin
         mN = 0; mHolding = 0; mRestart = 0; mCount = '0;
         scoreQ.delete();
      end else if (mHolding) begin
         if (wr) begin
            mHolding = 0;
            mCount = mCount + 16'd1;
            if (mRestart) begin mN = 0; mRestart = 0; end
         end
      end else if (v) begin
         hist.push_back(d);
         if (hist.size() > WL) void'(hist.pop_front());
         mN++;
         complete = (mN == WL) || (mN > WL && ((mN - WL) % S) == 0);
         if (complete) begin
            for (int i = 0; i < WL; i++) e.win[i*W +: W] = hist[hist.size()-1-i];
            e.cnt = mCount;
            scoreQ.push_back(e);
            mHolding = 1;
            mRestart = lst;
         end else if (lst) begin
            mN = 0;
         end
      end
   endtask

   // Monitor: every consumed window is matched against the oldest prediction.
   initial begin
      expWindow_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (window_valid_o === 1'b1 && window_ready_i && !reset_i) begin
            if (scoreQ.size() == 0) begin
               checkOutput("window_unexpected", 1, 0);
            end else begin
               e = scoreQ.pop_front();
               checkOutput("window_data", downstream, e.win);
               checkOutput("window_count_at_hs", window_count_o, e.cnt);
            end
         end
      end
   end

   initial begin
      bit lst;
      @(posedge clk_i);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0);
      // Fill with no consumer, then five cycles of backpressure with valid held high.
      for (int i = 0; i < WL; i++) applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0);
      for (int i = 0; i < 30; i++) applyStimulus(i % 2 == 0, 1, 0, 0);
      applyStimulus(0, 1, 1, 0);
      for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 1, 0);
      for (int i = 0; i < 25; i++) applyStimulus(1, 1, 0, 0);
`ifdef WINDOW_FRAME_LAST_EN
      applyStimulus(0, 1, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, i == 3);
      for (int i = 0; i < 14; i++) applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
`endif
      for (int i = 0; i < 3000; i++) begin
         lst = 0;
`ifdef WINDOW_FRAME_LAST_EN
         lst = ($urandom_range(0, 19) == 0);
`endif
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 399) == 0, lst);
      end
      for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 0);
      @(negedge clk_i);
      #3;
      checkOutput("scoreboard_drained", scoreQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
